// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared encodings for the multicycle control unit: FSM states,
//            opcode and funct values, ALUControl codes, ALU B-source selects
//            and the aluop codes driven into the ALU decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps the FSM's aluop request plus the instruction funct field to
//            the 3-bit ALUControl code, and flags whether funct is one of the
//            supported R-type operations.
// Ports    : aluop       in  2    00 add, 01 sub, 10 decode from funct
//            funct       in  FNW  instr[5:0]
//            alu_control out 3    ALU operation code
//            funct_valid out 1    funct is a supported R-type function
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
   import ctrl_pkg::*;
#(
   parameter int FNW = 6
) (
   input  logic [1:0]     aluop,
   input  logic [FNW-1:0] funct,
   output logic [2:0]     alu_control,
   output logic           funct_valid
);

   logic [2:0] w_funct_ctrl;

   // funct_valid is independent of aluop so DECODE can screen R-types early.
   always_comb begin
      w_funct_ctrl = ALU_ADD;
      funct_valid  = 1'b1;
      case (funct)
         FN_ADD:  w_funct_ctrl = ALU_ADD;
         FN_SUB:  w_funct_ctrl = ALU_SUB;
         FN_AND:  w_funct_ctrl = ALU_AND;
         FN_OR:   w_funct_ctrl = ALU_OR;
         FN_SLT:  w_funct_ctrl = ALU_SLT;
         default: funct_valid  = 1'b0;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_ADD:   alu_control = ALU_ADD;
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: alu_control = w_funct_ctrl;
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore FSM controller for the multicycle 32-bit datapath. Drives
//            all datapath selects/enables, handshakes memory via mem_ready.
// Ports    : clk, reset (async active-low)
//            opcode/funct  in   IR fields; zero in  ALU zero flag
//            mem_ready     in   memory completes current access
//            PCEn, PCSrcSel, IorDSel, IRWriteEn, MemRead, MemWrite,
//            RegWrite, RegDstSel, MemtoRegSel, ALUASrcSel   out 1
//            ALUBSrcSel out 2, ALUControl out 3
//            illegal_instr out 1 (pulse in DECODE), state_dbg out STW
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic [FNW-1:0] funct,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           PCEn,
   output logic           PCSrcSel,
   output logic           IorDSel,
   output logic           IRWriteEn,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           RegWrite,
   output logic           RegDstSel,
   output logic           MemtoRegSel,
   output logic           ALUASrcSel,
   output logic [1:0]     ALUBSrcSel,
   output logic [2:0]     ALUControl,
   output logic           illegal_instr,
   output logic [STW-1:0] state_dbg
);

   state_t     r_state;
   state_t     w_next_state;
   logic       w_pc_write;
   logic       w_branch;
   logic [1:0] w_aluop;
   logic       w_funct_valid;

   alu_decoder #(.FNW(FNW)) u_alu_decoder (
      .aluop       (w_aluop),
      .funct       (funct),
      .alu_control (ALUControl),
      .funct_valid (w_funct_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_pc_write    = 1'b0;
      w_branch      = 1'b0;
      w_aluop       = ALUOP_ADD;
      PCSrcSel      = 1'b0;
      IorDSel       = 1'b0;
      IRWriteEn     = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      RegDstSel     = 1'b0;
      MemtoRegSel   = 1'b0;
      ALUASrcSel    = 1'b0;
      ALUBSrcSel    = ALUB_REGB;
      illegal_instr = 1'b0;

      case (r_state)
         S_FETCH: begin
            MemRead    = 1'b1;
            ALUBSrcSel = ALUB_FOUR;
            if (mem_ready) begin
               IRWriteEn    = 1'b1;
               w_pc_write   = 1'b1;
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target computed speculatively into ALUOut.
            ALUBSrcSel = ALUB_IMMSH;
            case (opcode)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_ADDI:      w_next_state = S_ADDIEXEC;
               OP_RTYPE: begin
                  if (w_funct_valid) begin
                     w_next_state = S_EXECUTE;
                  end else begin
                     w_next_state  = S_FETCH;
                     illegal_instr = 1'b1;
                  end
               end
               default: begin
                  w_next_state  = S_FETCH;
                  illegal_instr = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUASrcSel   = 1'b1;
            ALUBSrcSel   = ALUB_IMM;
            w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorDSel = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) w_next_state = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoRegSel  = 1'b1;
            RegWrite     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEMWR: begin
            IorDSel  = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) w_next_state = S_FETCH;
         end
         S_EXECUTE: begin
            ALUASrcSel   = 1'b1;
            w_aluop      = ALUOP_FUNCT;
            w_next_state = S_ALUWB;
         end
         S_ALUWB: begin
            RegDstSel    = 1'b1;
            RegWrite     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            ALUASrcSel   = 1'b1;
            w_aluop      = ALUOP_SUB;
            w_branch     = 1'b1;
            PCSrcSel     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_ADDIEXEC: begin
            ALUASrcSel   = 1'b1;
            ALUBSrcSel   = ALUB_IMM;
            w_next_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite     = 1'b1;
            w_next_state = S_FETCH;
         end
         default: w_next_state = S_FETCH;
      endcase

      // Reset holds the state at FETCH, but FETCH would otherwise strobe
      // MemRead; squash every output to its idle value while reset is low.
      if (!reset) begin
         w_pc_write    = 1'b0;
         w_branch      = 1'b0;
         w_aluop       = ALUOP_ADD;
         PCSrcSel      = 1'b0;
         IorDSel       = 1'b0;
         IRWriteEn     = 1'b0;
         MemRead       = 1'b0;
         MemWrite      = 1'b0;
         RegWrite      = 1'b0;
         RegDstSel     = 1'b0;
         MemtoRegSel   = 1'b0;
         ALUASrcSel    = 1'b0;
         ALUBSrcSel    = ALUB_REGB;
         illegal_instr = 1'b0;
      end
   end

   assign PCEn      = w_pc_write | (w_branch & zero);
   assign state_dbg = STW'(r_state);

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed, table-driven bench for multicycle_control. Each table
//            row is one clock cycle: inputs plus the expected state and
//            outputs for that cycle. A hand sequence covers async reset
//            asserted in the middle of a memory read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCEn, PCSrcSel, IorDSel, IRWriteEn, MemRead, MemWrite;
   logic       RegWrite, RegDstSel, MemtoRegSel, ALUASrcSel;
   logic [1:0] ALUBSrcSel;
   logic [2:0] ALUControl;
   logic       illegal_instr;
   logic [3:0] state_dbg;

   multicycle_control #(.OPW(6), .FNW(6), .STW(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .PCEn          (PCEn),
      .PCSrcSel      (PCSrcSel),
      .IorDSel       (IorDSel),
      .IRWriteEn     (IRWriteEn),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .RegWrite      (RegWrite),
      .RegDstSel     (RegDstSel),
      .MemtoRegSel   (MemtoRegSel),
      .ALUASrcSel    (ALUASrcSel),
      .ALUBSrcSel    (ALUBSrcSel),
      .ALUControl    (ALUControl),
      .illegal_instr (illegal_instr),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   // Enable bit order: {PCEn,PCSrc,IorD,IRWrite,MemRead,MemWrite,
   //                    RegWrite,RegDst,MemtoReg,ALUA}
   localparam logic [9:0] E_NONE   = 10'b0000000000;
   localparam logic [9:0] E_FETCHR = 10'b1001100000;
   localparam logic [9:0] E_FETCHW = 10'b0000100000;
   localparam logic [9:0] E_ALUA   = 10'b0000000001;
   localparam logic [9:0] E_MEMRD  = 10'b0010100000;
   localparam logic [9:0] E_MEMWB  = 10'b0000001010;
   localparam logic [9:0] E_MEMWR  = 10'b0010010000;
   localparam logic [9:0] E_ALUWB  = 10'b0000001100;
   localparam logic [9:0] E_BRT    = 10'b1100000001;
   localparam logic [9:0] E_BRN    = 10'b0100000001;
   localparam logic [9:0] E_ADDIWB = 10'b0000001000;

   typedef struct {
      logic       rst_n;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       mr;
      logic [3:0] st;
      logic [9:0] en;
      logic [1:0] alub;
      logic [2:0] aluc;
      logic       ill;
      string      name;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic [9:0] en, input logic [1:0] ab,
                      input logic [2:0] ac, input logic il, input string nm);
      vec_t v;
      v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st;
      v.en = en; v.alub = ab; v.aluc = ac; v.ill = il; v.name = nm;
      vecs.push_back(v);
   endtask

   function automatic logic [19:0] actual();
      return {state_dbg, PCEn, PCSrcSel, IorDSel, IRWriteEn, MemRead, MemWrite,
              RegWrite, RegDstSel, MemtoRegSel, ALUASrcSel, ALUBSrcSel,
              ALUControl, illegal_instr};
   endfunction

   task automatic check(input string nm, input logic [19:0] exp);
      logic [19:0] act;
      act = actual();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %05h (st=%0d) expected %05h (st=%0d)",
                  nm, act, act[19:16], exp, exp[19:16]);
      end
   endtask

   // Drive at negedge, compare 1 ns later, well clear of the rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      reset = v.rst_n; opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.mr;
      #1;
      check(v.name, {v.st, v.en, v.alub, v.aluc, v.ill});
   endtask

   initial begin
      // Reset held 3 cycles with mem_ready high: outputs must stay idle.
      for (int i = 0; i < 3; i++)
         add(0, 6'h23, 6'h00, 0, 1, 4'd0, E_NONE, 2'b00, 3'b010, 0, "reset");
      // lw, mem_ready=1: 0,1,2,3,4
      add(1, 6'h23, 6'h00, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "lw_fetch");
      add(1, 6'h23, 6'h00, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "lw_decode");
      add(1, 6'h23, 6'h00, 0, 1, 4'd2, E_ALUA,   2'b10, 3'b010, 0, "lw_memadr");
      add(1, 6'h23, 6'h00, 0, 1, 4'd3, E_MEMRD,  2'b00, 3'b010, 0, "lw_memrd");
      add(1, 6'h23, 6'h00, 0, 1, 4'd4, E_MEMWB,  2'b00, 3'b010, 0, "lw_memwb");
      // sw with 3 wait cycles in MEMWR
      add(1, 6'h2B, 6'h00, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "sw_fetch");
      add(1, 6'h2B, 6'h00, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "sw_decode");
      add(1, 6'h2B, 6'h00, 0, 1, 4'd2, E_ALUA,   2'b10, 3'b010, 0, "sw_memadr");
      for (int i = 0; i < 3; i++)
         add(1, 6'h2B, 6'h00, 0, 0, 4'd5, E_MEMWR, 2'b00, 3'b010, 0, "sw_wait");
      add(1, 6'h2B, 6'h00, 0, 1, 4'd5, E_MEMWR,  2'b00, 3'b010, 0, "sw_memwr");
      // R-type slt, then sub
      add(1, 6'h00, 6'h2A, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "slt_fetch");
      add(1, 6'h00, 6'h2A, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "slt_decode");
      add(1, 6'h00, 6'h2A, 0, 0, 4'd6, E_ALUA,   2'b00, 3'b111, 0, "slt_execute");
      add(1, 6'h00, 6'h2A, 0, 1, 4'd7, E_ALUWB,  2'b00, 3'b010, 0, "slt_aluwb");
      add(1, 6'h00, 6'h22, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "sub_fetch");
      add(1, 6'h00, 6'h22, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "sub_decode");
      add(1, 6'h00, 6'h22, 0, 1, 4'd6, E_ALUA,   2'b00, 3'b110, 0, "sub_execute");
      add(1, 6'h00, 6'h22, 0, 1, 4'd7, E_ALUWB,  2'b00, 3'b010, 0, "sub_aluwb");
      // beq taken, then not taken (zero toggled outside BRANCH too)
      add(1, 6'h04, 6'h00, 1, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "beqt_fetch");
      add(1, 6'h04, 6'h00, 1, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "beqt_decode");
      add(1, 6'h04, 6'h00, 1, 1, 4'd8, E_BRT,    2'b00, 3'b110, 0, "beqt_branch");
      add(1, 6'h04, 6'h00, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "beqn_fetch");
      add(1, 6'h04, 6'h00, 1, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "beqn_decode");
      add(1, 6'h04, 6'h00, 0, 1, 4'd8, E_BRN,    2'b00, 3'b110, 0, "beqn_branch");
      // addi
      add(1, 6'h08, 6'h00, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "addi_fetch");
      add(1, 6'h08, 6'h00, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 0, "addi_decode");
      add(1, 6'h08, 6'h00, 0, 1, 4'd9, E_ALUA,   2'b10, 3'b010, 0, "addi_exec");
      add(1, 6'h08, 6'h00, 0, 1, 4'd10, E_ADDIWB, 2'b00, 3'b010, 0, "addi_wb");
      // illegal opcode, then R-type with unsupported funct
      add(1, 6'h3F, 6'h20, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "ill_op_fetch");
      add(1, 6'h3F, 6'h20, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 1, "ill_op_decode");
      add(1, 6'h00, 6'h00, 0, 1, 4'd0, E_FETCHR, 2'b01, 3'b010, 0, "ill_fn_fetch");
      add(1, 6'h00, 6'h00, 0, 1, 4'd1, E_NONE,   2'b11, 3'b010, 1, "ill_fn_decode");
      // FETCH waits for memory; illegal pulse must not persist
      add(1, 6'h00, 6'h00, 0, 0, 4'd0, E_FETCHW, 2'b01, 3'b010, 0, "fetch_wait");
      add(1, 6'h00, 6'h00, 0, 0, 4'd0, E_FETCHW, 2'b01, 3'b010, 0, "fetch_wait2");

      foreach (vecs[i]) apply(vecs[i]);

      // Async reset mid-MEMRD: lw up to a stalled MEMRD, then pull reset low
      // between clock edges.
      apply(vecs[3]);               // lw_fetch
      apply(vecs[4]);               // lw_decode
      apply(vecs[5]);               // lw_memadr
      begin
         vec_t v;
         v = vecs[6];
         v.mr = 0; v.name = "memrd_stall";
         apply(v);
      end
      #2 reset = 1'b0;
      #1 check("async_reset", {4'd0, E_NONE, 2'b00, 3'b010, 1'b0});
      @(negedge clk);
      mem_ready = 1'b1;
      #1 check("reset_hold", {4'd0, E_NONE, 2'b00, 3'b010, 1'b0});
      // Released: back to a clean fetch, the aborted lw never writes back.
      apply(vecs[3]);
      apply(vecs[4]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule : tb_multicycle_control
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle 32-bit datapath. It drives every select and enable input of the datapath.
- It is a Moore FSM on opcode/funct, with a mem_ready handshake for fetch and data accesses.
- It sits beside the datapath and consumes the datapath's instruction-register fields and the ALU zero flag.

Parameters:
- OPW, 6, opcode width.
- FNW, 6, funct width.
- STW, 4, state register width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPW  instr[31:26] from the instruction register.
- funct  in  FNW  instr[5:0] from the instruction register.
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current access this cycle.
- PCEn  out  1  PC register write enable.
- PCSrcSel  out  1  0 = ALU result, 1 = ALUOut register.
- IorDSel  out  1  memory address: 0 = PC, 1 = ALUOut.
- IRWriteEn  out  1  instruction register write.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write.
- RegDstSel  out  1  0 = rt, 1 = rd.
- MemtoRegSel  out  1  0 = ALUOut, 1 = memory data register.
- ALUASrcSel  out  1  0 = PC, 1 = register A.
- ALUBSrcSel  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_instr  out  1  one-cycle pulse on an unsupported instruction.
- state_dbg  out  STW  current state.

Behaviour:
- Reset low (async): state <= FETCH. While reset is low, all enables/strobes (PCEn, IRWriteEn, MemRead, MemWrite, RegWrite, illegal_instr) are forced to 0; all selects are 0 and ALUControl = 010.
- Outputs are decoded combinationally from the state. PCEn = PCWrite | (Branch & zero).
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
- States and actions (unlisted outputs are 0; ALUControl defaults to add):
  - FETCH (0): IorD=0, MemRead=1, ALUA=0, ALUB=01.
    - If mem_ready: IRWriteEn=1, PCWrite=1, PCSrc=0, go to DECODE.
    - Else stay; IRWriteEn and PCEn stay 0.
  - DECODE (1): ALUA=0, ALUB=11 (branch target into ALUOut). Next state by opcode:
    - lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC.
    - Any other opcode, or R-type with an unsupported funct -> FETCH with illegal_instr=1 for this cycle.
  - MEMADR (2): ALUA=1, ALUB=10. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): IorD=1, MemRead=1. Wait for mem_ready, then -> MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR (5): IorD=1, MemWrite=1, held until mem_ready -> FETCH. Exactly one cycle with MemWrite & mem_ready.
  - EXECUTE (6): ALUA=1, ALUB=00, ALUControl from funct -> ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH (8): ALUA=1, ALUB=00, ALUControl=110, Branch=1, PCSrc=1 -> FETCH. PCEn = zero.
  - ADDIEXEC (9): ALUA=1, ALUB=10, add -> ADDIWB.
  - ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- Unused state encodings (11-15) -> FETCH next cycle, all enables 0.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- opcode/funct are sampled only in DECODE, EXECUTE and MEMADR; they are stable then because the IR is written only in FETCH.
- zero matters only in BRANCH.
- Reset asserted mid-instruction: abort immediately to FETCH; no further RegWrite/MemWrite for that instruction.
- mem_ready during a non-memory state: ignored.

Decomposition:
- Shared package (ctrl_pkg):
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - funct constants;
  - ALUControl codes;
  - ALUBSrcSel codes.
- One sub-module: alu_decoder. Inputs: aluop[1:0] (00 add, 01 sub, 10 use funct) and funct. Outputs: ALUControl and a funct_valid flag used in DECODE.

Test Plan:
- Reset low for 3 cycles, then release with mem_ready=1: state_dbg=0 and all enables 0 during reset. The first post-reset cycle shows MemRead=1, IRWriteEn=1, PCEn=1, ALUB=01.
- lw (opcode 0x23), mem_ready=1: states 0,1,2,3,4,0. In state 4, RegWrite=1, MemtoReg=1, RegDst=0.
- sw with mem_ready low for 3 cycles in MEMWR: MemWrite held high 4 cycles. Exactly one cycle has MemWrite & mem_ready. RegWrite is never asserted. Then FETCH.
- R-type funct 0x2A: EXECUTE shows ALUControl=111, ALUA=1, ALUB=00. ALUWB shows RegDst=1, RegWrite=1. Repeat for funct 0x22 (expect ALUControl=110).
- beq with zero=1, then beq with zero=0: BRANCH state shows PCEn=1, PCSrc=1, ALUControl=110 for the first and PCEn=0 for the second. Both take 3 cycles.
- opcode 0x3F, and R-type funct 0x00: illegal_instr pulses for 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite. Reset asserted during MEMRD returns state_dbg to 0 asynchronously.
